alu_operand_b_stage: RTL and testbench

Parametrised, registered successor to the ALU source-B operand mux of the multicycle datapath. Selects one of `NUM_SRC` external operands or one of four internally generated operands (constant, sign-extended, sign-extended-shifted and zero-extended immediate), then registers the result behind a valid/ready handshake. Sits between the register/immediate stage and the ALU input B. Invalid selects produce a defined zero output and a sticky error flag instead of holding a stale value.

---
 rtl/alu_operand_b_stage.sv | 175 +++++++++++++++++
 tb/tb_alu_operand_b_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_b_stage.sv
// alu_operand_b_stage
//
// Registered ALU source-B operand selector. It picks one of NUM_SRC external
// operands or one of four generated operands, and presents the result behind
// a valid/ready handshake.
//
//   sel < NUM_SRC : src_flat[sel*WIDTH +: WIDTH]
//   NUM_SRC       : CONST_VAL
//   NUM_SRC+1     : sign-extended imm16
//   NUM_SRC+2     : sign-extended imm16 << 2
//   NUM_SRC+3     : zero-extended imm16
//   other         : invalid; stores 0 and sets the sticky err_sel flag
//
// Build option: define ALU_OPB_SKID_EN to add a one-entry skid register
// behind the output register. With the skid, in_ready is registered and has
// no path from out_ready. Without it, in_ready = !out_valid || out_ready.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   upstream offers sel/src_flat/imm16
//   in_ready   stage accepts a transfer this cycle
//   sel        source select
//   src_flat   packed external sources, source k at [k*WIDTH +: WIDTH]
//   imm16      raw instruction immediate
//   out_valid  out_data/out_sel hold a valid operand
//   out_ready  ALU side consumes the operand
//   out_data   selected operand
//   out_sel    select that produced out_data
//   err_sel    sticky flag: an invalid select was accepted
//   err_clr    synchronous clear of err_sel (a new error wins)

module alu_operand_b_stage #(
    parameter int          WIDTH     = 32,
    parameter int          NUM_SRC   = 4,
    parameter int          SEL_W     = 3,
    parameter int unsigned CONST_VAL = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_flat,
    input  logic [15:0]              imm16,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     err_sel,
    input  logic                     err_clr
);

    localparam logic [SEL_W-1:0] SEL_CONST = SEL_W'(NUM_SRC);
    localparam logic [SEL_W-1:0] SEL_SEXT  = SEL_W'(NUM_SRC + 1);
    localparam logic [SEL_W-1:0] SEL_SHFT  = SEL_W'(NUM_SRC + 2);
    localparam logic [SEL_W-1:0] SEL_ZEXT  = SEL_W'(NUM_SRC + 3);
    localparam logic [WIDTH-1:0] CONST_W   = WIDTH'(CONST_VAL);

    logic [WIDTH-1:0] sext_imm;
    logic [WIDTH-1:0] zext_imm;
    logic [WIDTH-1:0] dec_data;
    logic             dec_bad;
    logic             accept;
    logic             consume;

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic [SEL_W-1:0] main_sel;
    logic             err_q;

    assign sext_imm = {{(WIDTH-16){imm16[15]}}, imm16};
    assign zext_imm = {{(WIDTH-16){1'b0}}, imm16};

    always_comb begin
        dec_data = '0;
        dec_bad  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                dec_data = src_flat[k*WIDTH +: WIDTH];
                dec_bad  = 1'b0;
            end
        end
        if (sel == SEL_CONST) begin
            dec_data = CONST_W;
            dec_bad  = 1'b0;
        end else if (sel == SEL_SEXT) begin
            dec_data = sext_imm;
            dec_bad  = 1'b0;
        end else if (sel == SEL_SHFT) begin
            dec_data = {sext_imm[WIDTH-3:0], 2'b00};
            dec_bad  = 1'b0;
        end else if (sel == SEL_ZEXT) begin
            dec_data = zext_imm;
            dec_bad  = 1'b0;
        end
    end

    assign accept  = in_valid && in_ready;
    assign consume = main_valid && out_ready;

`ifdef ALU_OPB_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;

    // skid_valid is a flop, so in_ready never depends on out_ready.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_sel   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
        end else if (consume) begin
            if (skid_valid) begin
                // in_ready is low here, so no new transfer competes for main.
                main_data  <= skid_data;
                main_sel   <= skid_sel;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= dec_data;
                main_sel   <= sel;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (!main_valid) begin
            if (accept) begin
                main_valid <= 1'b1;
                main_data  <= dec_data;
                main_sel   <= sel;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= dec_data;
            skid_sel   <= sel;
        end
    end
`else
    assign in_ready = !main_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_sel   <= '0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= dec_data;
            main_sel   <= sel;
        end else if (consume) begin
            main_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && dec_bad) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_sel   = main_sel;
    assign err_sel   = err_q;

endmodule

// File: tb/tb_alu_operand_b_stage.sv
module tb_alu_operand_b_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;

    // dut: NUM_SRC=4, every select value is legal
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   sel = 3'd0;
    logic [127:0] src_flat;
    logic [15:0]  imm16 = 16'h0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic [2:0]   out_sel;
    logic         err_sel;
    logic         err_clr = 1'b0;

    // dut3: NUM_SRC=3, sel=7 is invalid
    logic         in_valid3 = 1'b0;
    logic         in_ready3;
    logic [2:0]   sel3 = 3'd0;
    logic [95:0]  src_flat3;
    logic         out_valid3;
    logic         out_ready3 = 1'b1;
    logic [31:0]  out_data3;
    logic [2:0]   out_sel3;
    logic         err_sel3;
    logic         err_clr3 = 1'b0;

    int tests = 0;
    int fails = 0;

    assign src_flat  = {32'h12345678, 32'hDEADBEEF, 32'h5A5A5A5A, 32'hA5A5A5A5};
    assign src_flat3 = {32'hDEADBEEF, 32'h5A5A5A5A, 32'hA5A5A5A5};

    alu_operand_b_stage #(.WIDTH(32), .NUM_SRC(4), .SEL_W(3), .CONST_VAL(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .src_flat(src_flat), .imm16(imm16), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
        .err_sel(err_sel), .err_clr(err_clr)
    );

    alu_operand_b_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(3), .CONST_VAL(4)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .sel(sel3), .src_flat(src_flat3), .imm16(imm16), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .out_sel(out_sel3),
        .err_sel(err_sel3), .err_clr(err_clr3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'd4, 16'h0000, 32'h00000004};
        vecs[1]  = '{3'd5, 16'hFFFC, 32'hFFFFFFFC};
        vecs[2]  = '{3'd6, 16'hFFFC, 32'hFFFFFFF0};
        vecs[3]  = '{3'd7, 16'hFFFC, 32'h0000FFFC};
        vecs[4]  = '{3'd0, 16'h1234, 32'hA5A5A5A5};
        vecs[5]  = '{3'd1, 16'h1234, 32'h5A5A5A5A};
        vecs[6]  = '{3'd2, 16'h1234, 32'hDEADBEEF};
        vecs[7]  = '{3'd3, 16'h1234, 32'h12345678};
        vecs[8]  = '{3'd5, 16'h7FFF, 32'h00007FFF};
        vecs[9]  = '{3'd6, 16'h7FFF, 32'h0001FFFC};
        vecs[10] = '{3'd6, 16'h8001, 32'hFFFE0004};
        vecs[11] = '{3'd7, 16'h8001, 32'h00008001};

        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_err_sel", 32'(err_sel), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        step();

        // streaming decode, one transfer per cycle
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            sel      = vecs[i].sel;
            imm16    = vecs[i].imm;
            step();
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_sel", i), 32'(out_sel), 32'(vecs[i].sel));
        end
        in_valid = 1'b0;
        step();
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // back-pressure: sources 0 then 1 with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 3'd0;
        step();
        check("stall_first_valid", 32'(out_valid), 32'd1);
        check("stall_first_data", out_data, 32'hA5A5A5A5);
        sel = 3'd1;
`ifdef ALU_OPB_SKID_EN
        check("stall_in_ready_pre", 32'(in_ready), 32'd1);
        step();
        check("skid_in_ready_low", 32'(in_ready), 32'd0);
        check("skid_hold_data", out_data, 32'hA5A5A5A5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("skid_second_valid", 32'(out_valid), 32'd1);
        check("skid_second_data", out_data, 32'h5A5A5A5A);
        check("skid_in_ready_back", 32'(in_ready), 32'd1);
        step();
        check("skid_drained", 32'(out_valid), 32'd0);
`else
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        step();
        check("stall_hold_data", out_data, 32'hA5A5A5A5);
        check("stall_hold_sel", 32'(out_sel), 32'd0);
        out_ready = 1'b1;
        #1;
        check("comb_in_ready", 32'(in_ready), 32'd1);
        step();
        check("stall_second_data", out_data, 32'h5A5A5A5A);
        check("stall_second_sel", 32'(out_sel), 32'd1);
        in_valid = 1'b0;
        step();
        check("stall_drained", 32'(out_valid), 32'd0);
`endif

        // sticky error flag on dut3
        in_valid3 = 1'b1;
        sel3      = 3'd7;
        step();
        check("err_valid", 32'(out_valid3), 32'd1);
        check("err_data_zero", out_data3, 32'd0);
        check("err_set", 32'(err_sel3), 32'd1);
        sel3 = 3'd0;
        step();
        check("err_ok_data", out_data3, 32'hA5A5A5A5);
        check("err_holds", 32'(err_sel3), 32'd1);
        in_valid3 = 1'b0;
        err_clr3  = 1'b1;
        step();
        check("err_cleared", 32'(err_sel3), 32'd0);
        in_valid3 = 1'b1;
        sel3      = 3'd7;
        step();
        check("err_set_wins", 32'(err_sel3), 32'd1);
        in_valid3 = 1'b0;
        step();
        check("err_clr_again", 32'(err_sel3), 32'd0);
        err_clr3 = 1'b0;

        // reset while stalled with storage full
        out_ready  = 1'b0;
        out_ready3 = 1'b0;
        in_valid   = 1'b1;
        sel        = 3'd2;
        in_valid3  = 1'b1;
        sel3       = 3'd7;
        step();
        in_valid3 = 1'b0;
        sel       = 3'd3;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_data", out_data, 32'hDEADBEEF);
        check("pre_rst_err3", 32'(err_sel3), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_valid3", 32'(out_valid3), 32'd0);
        check("async_rst_err3", 32'(err_sel3), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        reset      = 1'b0;
        out_ready  = 1'b1;
        out_ready3 = 1'b1;
        in_valid   = 1'b1;
        sel        = 3'd3;
        in_valid3  = 1'b1;
        sel3       = 3'd6;
        imm16      = 16'h8001;
        step();
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        check("post_rst_data", out_data, 32'h12345678);
        check("post_rst_sel", 32'(out_sel), 32'd3);
        check("post_rst_data3", out_data3, 32'h00008001);
        step();
        check("post_rst_drain", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
